wb_stage: RTL and testbench

- Writeback stage directly upstream of the 16x16 register file; drives its write port (WriteReg, DstReg, DstData).
- Accepts one retiring instruction per cycle from the MEM stage and selects the result source: ALU, memory, PC+2, or LLB/LHB byte merge.
- Waits on multi-cycle load data through a small FSM, then issues exactly one registered write pulse per retired instruction.

---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_result_mux.sv | 41 ++++
 rtl/wb_stage.sv | 142 ++++++++++++++
 tb/tb_wb_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the writeback stage: datapath widths, result-source
// select encodings, FSM state encodings and the hardwired-zero register index.
// Optional feature macro used by wb_stage: WB_RETIRE_COUNT_EN.
// ----------------------------------------------------------------------------
package wb_pkg;

   localparam int DATA_W     = 16;
   localparam int REG_ADDR_W = 4;

   // Writeback result source, as carried on InWbSel
   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_MEM  = 2'b01,
      WB_PC   = 2'b10,
      WB_BYTE = 2'b11
   } wb_sel_e;

   // Writeback control FSM
   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } wb_state_e;

   // R0 reads as zero and is never written
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'h0;

endpackage

// File: rtl/wb_result_mux.sv
// ----------------------------------------------------------------------------
// wb_result_mux
// Purely combinational writeback source selection, including the LLB/LHB
// byte merge against the destination's prior value.
// Ports:
//   sel        - source select (ALU, MEM, PC+2, byte immediate)
//   byte_hi    - for the byte-immediate source: 1 = LHB, 0 = LLB
//   alu_result - ALU result
//   mem_data   - load data
//   pc_plus2   - return address
//   imm8       - byte immediate
//   old_val    - destination's prior value
//   result     - selected writeback value
// ----------------------------------------------------------------------------
module wb_result_mux
   import wb_pkg::*;
(
   input  logic [1:0]        sel,
   input  logic              byte_hi,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] pc_plus2,
   input  logic [7:0]        imm8,
   input  logic [DATA_W-1:0] old_val,
   output logic [DATA_W-1:0] result
);

   // LLB replaces the low byte, LHB the high byte; the other byte is kept
   // from the destination's value read at decode.
   always_comb begin
      result = alu_result;
      case (sel)
         WB_ALU:  result = alu_result;
         WB_MEM:  result = mem_data;
         WB_PC:   result = pc_plus2;
         WB_BYTE: result = byte_hi ? {imm8, old_val[7:0]} : {old_val[15:8], imm8};
         default: result = alu_result;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// ----------------------------------------------------------------------------
// wb_stage
// Writeback stage feeding the 16x16 register file write port. Accepts one
// retiring instruction per cycle, waits for late load data in WAIT_MEM and
// issues exactly one registered write/retire pulse per instruction.
// Optional feature: define WB_RETIRE_COUNT_EN to add the 32-bit RetireCount
// and WriteCount outputs.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   InValid       - MEM stage presents an instruction
//   InReady       - stage can accept (state is IDLE)
//   Flush         - squash pending/incoming instruction
//   InRegWrite    - instruction writes a register
//   InDstReg      - destination index
//   InWbSel       - result source select
//   InByteHi      - LHB (1) / LLB (0) for byte-immediate source
//   InAluResult, InPcPlus2, InImm8, InOldVal - result sources
//   MemDataValid  - load data available this cycle
//   MemData       - load data
//   WriteReg      - register-file write enable pulse
//   DstReg        - register-file write index
//   DstData       - register-file write data
//   Retire        - one pulse per retired instruction
//   RetireCount   - (optional) number of Retire pulses, wrapping
//   WriteCount    - (optional) number of WriteReg pulses, wrapping
// ----------------------------------------------------------------------------
module wb_stage
   import wb_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  InValid,
   output logic                  InReady,
   input  logic                  Flush,
   input  logic                  InRegWrite,
   input  logic [REG_ADDR_W-1:0] InDstReg,
   input  logic [1:0]            InWbSel,
   input  logic                  InByteHi,
   input  logic [DATA_W-1:0]     InAluResult,
   input  logic [DATA_W-1:0]     InPcPlus2,
   input  logic [7:0]            InImm8,
   input  logic [DATA_W-1:0]     InOldVal,
   input  logic                  MemDataValid,
   input  logic [DATA_W-1:0]     MemData,
   output logic                  WriteReg,
   output logic [REG_ADDR_W-1:0] DstReg,
   output logic [DATA_W-1:0]     DstData,
   output logic                  Retire
`ifdef WB_RETIRE_COUNT_EN
   ,
   output logic [31:0]           RetireCount,
   output logic [31:0]           WriteCount
`endif
);

   wb_state_e             state;
   logic                  pend_reg_write;
   logic [REG_ADDR_W-1:0] pend_dst;
   logic [DATA_W-1:0]     sel_value;
   logic                  accept;
   logic                  in_write;
   logic                  pend_write;

   wb_result_mux u_mux (
      .sel        (InWbSel),
      .byte_hi    (InByteHi),
      .alu_result (InAluResult),
      .mem_data   (MemData),
      .pc_plus2   (InPcPlus2),
      .imm8       (InImm8),
      .old_val    (InOldVal),
      .result     (sel_value)
   );

   // InReady is a decode of the registered state, so it is glitch-free and
   // goes high immediately on reset.
   assign InReady    = (state == IDLE);
   assign accept     = InValid & InReady & ~Flush;
   assign in_write   = InRegWrite & (InDstReg != REG_ZERO);
   assign pend_write = pend_reg_write & (pend_dst != REG_ZERO);

   // Control FSM and all output registers. Outputs default to zero every
   // cycle so each pulse lasts exactly one cycle. Flush in WAIT_MEM takes
   // priority over arriving load data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         pend_reg_write <= 1'b0;
         pend_dst       <= REG_ZERO;
         WriteReg       <= 1'b0;
         Retire         <= 1'b0;
         DstReg         <= REG_ZERO;
         DstData        <= '0;
`ifdef WB_RETIRE_COUNT_EN
         RetireCount    <= 32'd0;
         WriteCount     <= 32'd0;
`endif
      end else begin
         WriteReg <= 1'b0;
         Retire   <= 1'b0;
         DstReg   <= REG_ZERO;
         DstData  <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if ((InWbSel != WB_MEM) || MemDataValid) begin
                     Retire   <= 1'b1;
                     WriteReg <= in_write;
                     DstReg   <= InDstReg;
                     DstData  <= sel_value;
`ifdef WB_RETIRE_COUNT_EN
                     RetireCount <= RetireCount + 32'd1;
                     WriteCount  <= WriteCount + {31'd0, in_write};
`endif
                  end else begin
                     pend_reg_write <= InRegWrite;
                     pend_dst       <= InDstReg;
                     state          <= WAIT_MEM;
                  end
               end
            end
            WAIT_MEM: begin
               if (Flush) begin
                  state <= IDLE;
               end else if (MemDataValid) begin
                  Retire   <= 1'b1;
                  WriteReg <= pend_write;
                  DstReg   <= pend_dst;
                  DstData  <= MemData;
                  state    <= IDLE;
`ifdef WB_RETIRE_COUNT_EN
                  RetireCount <= RetireCount + 32'd1;
                  WriteCount  <= WriteCount + {31'd0, pend_write};
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_wb_stage
// Self-checking bench for wb_stage: directed vectors with literal expectations
// plus a cycle-level behavioural model compared against the DUT every cycle.
// Honours WB_RETIRE_COUNT_EN when it is defined for the build.
// ----------------------------------------------------------------------------
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        InValid = 1'b0;
   logic        InReady;
   logic        Flush = 1'b0;
   logic        InRegWrite = 1'b0;
   logic [3:0]  InDstReg = 4'h0;
   logic [1:0]  InWbSel = 2'b00;
   logic        InByteHi = 1'b0;
   logic [15:0] InAluResult = 16'h0;
   logic [15:0] InPcPlus2 = 16'h0;
   logic [7:0]  InImm8 = 8'h0;
   logic [15:0] InOldVal = 16'h0;
   logic        MemDataValid = 1'b0;
   logic [15:0] MemData = 16'h0;
   logic        WriteReg;
   logic [3:0]  DstReg;
   logic [15:0] DstData;
   logic        Retire;
`ifdef WB_RETIRE_COUNT_EN
   logic [31:0] RetireCount;
   logic [31:0] WriteCount;
`endif

   int nChecks = 0;
   int nFails  = 0;

   wb_stage dut (
      .clk          (clk),
      .rst          (rst),
      .InValid      (InValid),
      .InReady      (InReady),
      .Flush        (Flush),
      .InRegWrite   (InRegWrite),
      .InDstReg     (InDstReg),
      .InWbSel      (InWbSel),
      .InByteHi     (InByteHi),
      .InAluResult  (InAluResult),
      .InPcPlus2    (InPcPlus2),
      .InImm8       (InImm8),
      .InOldVal     (InOldVal),
      .MemDataValid (MemDataValid),
      .MemData      (MemData),
      .WriteReg     (WriteReg),
      .DstReg       (DstReg),
      .DstData      (DstData),
      .Retire       (Retire)
`ifdef WB_RETIRE_COUNT_EN
      ,
      .RetireCount  (RetireCount),
      .WriteCount   (WriteCount)
`endif
   );

   // 10-unit clock; inputs change and outputs are sampled on the falling edge
   always #5 clk = ~clk;

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs and returns at the next falling edge, where
   // the outputs produced by that cycle are visible.
   task automatic applyStimulus(input logic valid, input logic flush, input logic regWrite,
                                input logic [3:0] dst, input logic [1:0] sel, input logic byteHi,
                                input logic [15:0] alu, input logic [15:0] pc, input logic [7:0] imm,
                                input logic [15:0] oldVal, input logic memValid, input logic [15:0] memData);
      InValid      = valid;
      Flush        = flush;
      InRegWrite   = regWrite;
      InDstReg     = dst;
      InWbSel      = sel;
      InByteHi     = byteHi;
      InAluResult  = alu;
      InPcPlus2    = pc;
      InImm8       = imm;
      InOldVal     = oldVal;
      MemDataValid = memValid;
      MemData      = memData;
      @(negedge clk);
   endtask

   task automatic idleCycle(input logic memValid, input logic [15:0] memData);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 16'hDEAD, 16'h0, 8'h0, 16'h0, memValid, memData);
   endtask

   // ---------------- behavioural model ----------------
   // Tracks whether a load is outstanding and what must appear on the write
   // port after each clock, straight from the stage's retirement rules.
   logic        mBusy = 1'b0;
   logic        mPendWrite = 1'b0;
   logic [3:0]  mPendDst = 4'h0;
   logic        expWrite = 1'b0;
   logic        expRetire = 1'b0;
   logic [3:0]  expDst = 4'h0;
   logic [15:0] expData = 16'h0;
   int unsigned mRetires = 0;
   int unsigned mWrites = 0;

   function automatic logic [15:0] refValue(input logic [1:0] sel, input logic byteHi,
                                            input logic [15:0] alu, input logic [15:0] mem,
                                            input logic [15:0] pc, input logic [7:0] imm,
                                            input logic [15:0] oldVal);
      logic [15:0] immWide;
      immWide = {8'h00, imm};
      if (sel == 2'd0) return alu;
      if (sel == 2'd1) return mem;
      if (sel == 2'd2) return pc;
      if (byteHi) return (immWide << 8) | (oldVal & 16'h00FF);
      return (oldVal & 16'hFF00) | immWide;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mBusy     <= 1'b0;
         expWrite  <= 1'b0;
         expRetire <= 1'b0;
         expDst    <= 4'h0;
         expData   <= 16'h0;
         mRetires  <= 0;
         mWrites   <= 0;
      end else begin
         expWrite  <= 1'b0;
         expRetire <= 1'b0;
         expDst    <= 4'h0;
         expData   <= 16'h0;
         if (!mBusy) begin
            if (InValid && !Flush) begin
               if (InWbSel == 2'd1 && !MemDataValid) begin
                  mBusy      <= 1'b1;
                  mPendWrite <= InRegWrite && (InDstReg != 4'd0);
                  mPendDst   <= InDstReg;
               end else begin
                  expRetire <= 1'b1;
                  expWrite  <= InRegWrite && (InDstReg != 4'd0);
                  expDst    <= InDstReg;
                  expData   <= refValue(InWbSel, InByteHi, InAluResult, MemData, InPcPlus2, InImm8, InOldVal);
                  mRetires  <= mRetires + 1;
                  mWrites   <= mWrites + ((InRegWrite && (InDstReg != 4'd0)) ? 1 : 0);
               end
            end
         end else if (Flush) begin
            mBusy <= 1'b0;
         end else if (MemDataValid) begin
            mBusy     <= 1'b0;
            expRetire <= 1'b1;
            expWrite  <= mPendWrite;
            expDst    <= mPendDst;
            expData   <= MemData;
            mRetires  <= mRetires + 1;
            mWrites   <= mWrites + (mPendWrite ? 1 : 0);
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("model WriteReg", {31'd0, WriteReg}, {31'd0, expWrite});
         checkOutput("model Retire",   {31'd0, Retire},   {31'd0, expRetire});
         checkOutput("model DstReg",   {28'd0, DstReg},   {28'd0, expDst});
         checkOutput("model DstData",  {16'd0, DstData},  {16'd0, expData});
         checkOutput("model InReady",  {31'd0, InReady},  {31'd0, !mBusy});
`ifdef WB_RETIRE_COUNT_EN
         checkOutput("model RetireCount", RetireCount, mRetires);
         checkOutput("model WriteCount",  WriteCount,  mWrites);
`endif
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset WriteReg", {31'd0, WriteReg}, 32'd0);
      checkOutput("reset Retire",   {31'd0, Retire},   32'd0);
      checkOutput("reset DstReg",   {28'd0, DstReg},   32'd0);
      checkOutput("reset DstData",  {16'd0, DstData},  32'd0);
      checkOutput("reset InReady",  {31'd0, InReady},  32'd1);
      rst = 1'b0;
      idleCycle(1'b0, 16'h0);

      // ALU op to R3
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd3, 2'b00, 1'b0, 16'h1234, 16'h0, 8'h0, 16'h0, 1'b0, 16'h0);
      checkOutput("alu WriteReg", {31'd0, WriteReg}, 32'd1);
      checkOutput("alu DstReg",   {28'd0, DstReg},   32'd3);
      checkOutput("alu DstData",  {16'd0, DstData},  32'h1234);
      checkOutput("alu Retire",   {31'd0, Retire},   32'd1);
      idleCycle(1'b1, 16'h7777);
      checkOutput("alu pulse ends", {31'd0, WriteReg}, 32'd0);
      checkOutput("idle memvalid ignored", {31'd0, Retire}, 32'd0);

      // PC+2 source
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd15, 2'b10, 1'b0, 16'h1111, 16'h0042, 8'h0, 16'h0, 1'b0, 16'h0);
      checkOutput("pcs DstData", {16'd0, DstData}, 32'h0042);

      // Load with data three cycles later
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd5, 2'b01, 1'b0, 16'h0, 16'h0, 8'h0, 16'h0, 1'b0, 16'h0);
      checkOutput("load wait1 InReady", {31'd0, InReady}, 32'd0);
      idleCycle(1'b0, 16'h1111);
      checkOutput("load wait2 InReady", {31'd0, InReady}, 32'd0);
      checkOutput("load wait2 WriteReg", {31'd0, WriteReg}, 32'd0);
      idleCycle(1'b0, 16'h2222);
      checkOutput("load wait3 InReady", {31'd0, InReady}, 32'd0);
      idleCycle(1'b1, 16'hBEEF);
      checkOutput("load WriteReg", {31'd0, WriteReg}, 32'd1);
      checkOutput("load DstReg",   {28'd0, DstReg},   32'd5);
      checkOutput("load DstData",  {16'd0, DstData},  32'hBEEF);
      checkOutput("load InReady",  {31'd0, InReady},  32'd1);
      idleCycle(1'b0, 16'h0);
      checkOutput("load single pulse", {31'd0, WriteReg}, 32'd0);

      // Load with data already present retires in one cycle
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd6, 2'b01, 1'b0, 16'h0, 16'h0, 8'h0, 16'h0, 1'b1, 16'hCAFE);
      checkOutput("fast load DstData", {16'd0, DstData}, 32'hCAFE);

      // LLB then LHB
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd7, 2'b11, 1'b0, 16'h0, 16'h0, 8'h3C, 16'hAABB, 1'b0, 16'h0);
      checkOutput("llb DstData", {16'd0, DstData}, 32'hAA3C);
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd8, 2'b11, 1'b1, 16'h0, 16'h0, 8'h3C, 16'hAABB, 1'b0, 16'h0);
      checkOutput("lhb DstData", {16'd0, DstData}, 32'h3CBB);

      // R0 destination and non-writing instruction
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd0, 2'b00, 1'b0, 16'h5555, 16'h0, 8'h0, 16'h0, 1'b0, 16'h0);
      checkOutput("r0 WriteReg", {31'd0, WriteReg}, 32'd0);
      checkOutput("r0 Retire",   {31'd0, Retire},   32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd2, 2'b00, 1'b0, 16'h6666, 16'h0, 8'h0, 16'h0, 1'b0, 16'h0);
      checkOutput("nowrite WriteReg", {31'd0, WriteReg}, 32'd0);
      checkOutput("nowrite Retire",   {31'd0, Retire},   32'd1);

      // Flush with InValid in IDLE
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd9, 2'b00, 1'b0, 16'h9999, 16'h0, 8'h0, 16'h0, 1'b0, 16'h0);
      checkOutput("idle flush Retire", {31'd0, Retire}, 32'd0);

      // Flush in WAIT_MEM beats simultaneous data
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd6, 2'b01, 1'b0, 16'h0, 16'h0, 8'h0, 16'h0, 1'b0, 16'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 2'b00, 1'b0, 16'h0, 16'h0, 8'h0, 16'h0, 1'b1, 16'hF00D);
      checkOutput("flush WriteReg", {31'd0, WriteReg}, 32'd0);
      checkOutput("flush Retire",   {31'd0, Retire},   32'd0);
      checkOutput("flush InReady",  {31'd0, InReady},  32'd1);
      idleCycle(1'b1, 16'hF00D);
      checkOutput("flush stays dropped", {31'd0, Retire}, 32'd0);

      // Async reset between edges while a load is pending
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd9, 2'b01, 1'b0, 16'h0, 16'h0, 8'h0, 16'h0, 1'b0, 16'h0);
      checkOutput("prereset InReady", {31'd0, InReady}, 32'd0);
      InValid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkOutput("async rst InReady",  {31'd0, InReady},  32'd1);
      checkOutput("async rst WriteReg", {31'd0, WriteReg}, 32'd0);
      checkOutput("async rst Retire",   {31'd0, Retire},   32'd0);
      checkOutput("async rst DstData",  {16'd0, DstData},  32'd0);
      @(negedge clk);
      rst = 1'b0;
`ifdef WB_RETIRE_COUNT_EN
      checkOutput("count after reset", RetireCount, 32'd0);
`endif
      idleCycle(1'b1, 16'hABCD);
      checkOutput("lost load no Retire", {31'd0, Retire}, 32'd0);

      // Back-to-back ALU ops to R1..R4
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 4'(i), 2'b00, 1'b0, 16'h1000 + 16'(i), 16'h0, 8'h0, 16'h0, 1'b0, 16'h0);
         checkOutput("b2b WriteReg", {31'd0, WriteReg}, 32'd1);
         checkOutput("b2b DstReg",   {28'd0, DstReg},   32'(i));
         checkOutput("b2b DstData",  {16'd0, DstData},  32'h1000 + 32'(i));
      end
      idleCycle(1'b0, 16'h0);
`ifdef WB_RETIRE_COUNT_EN
      checkOutput("b2b RetireCount", RetireCount, 32'd4);
      checkOutput("b2b WriteCount",  WriteCount,  32'd4);
`endif
      idleCycle(1'b0, 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
